// File: rtl/aes_inv_mixcol.sv
// rtl/aes_inv_mixcol.sv - AES InvMixColumns, COLS_PER_CYC columns per clock with valid/ready handshake
module aes_inv_mixcol #(
    parameter int COLS_PER_CYC = 1
) (
    input  logic         CLK,
    input  logic         RSTB,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [127:0] IN_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [127:0] OUT_DATA
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Step as seen by the 2-bit column counter (4 wraps to 0) and by the 3-bit end-of-pass test.
    localparam logic [1:0] STEP2 = 2'(COLS_PER_CYC);
    localparam logic [2:0] STEP3 = 3'(COLS_PER_CYC);

    state_t         state_q, state_d;
    logic [127:0]   data_q, data_d;
    logic [1:0]     cnt_q, cnt_d;
    logic           last_step;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] b  [4];
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        for (int r = 0; r < 4; r++) begin
            b[r] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    assign last_step = (({1'b0, cnt_q} + STEP3) == 3'd4);

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (IN_VALID)  state_d = S_BUSY;
            S_BUSY:  if (last_step) state_d = S_DONE;
            S_DONE:  if (OUT_READY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        IN_READY  = (state_q == S_IDLE);
        OUT_VALID = (state_q == S_DONE);
    end

    // Columns are rewritten in place, lowest index first; the counter wraps to 0 as BUSY ends.
    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (IN_VALID) begin
                    data_d = IN_DATA;
                    cnt_d  = 2'd0;
                end
            end
            S_BUSY: begin
                for (int k = 0; k < COLS_PER_CYC; k++) begin
                    data_d[7'd127 - {cnt_q + 2'(k), 5'd0} -: 32] =
                        inv_col(data_q[7'd127 - {cnt_q + 2'(k), 5'd0} -: 32]);
                end
                cnt_d = cnt_q + STEP2;
            end
            default: begin
                data_d = data_q;
                cnt_d  = cnt_q;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign OUT_DATA = data_q;

endmodule

// File: doc/aes_inv_mixcol.md
AES_INV_MIXCOL -- requirements
Module: aes_inv_mixcol

Interface
REQ-001 Parameter COLS_PER_CYC, default 1: number of state columns transformed per clock; only the values 1, 2 and 4 are legal.
REQ-002 CLK  input  1  single clock; all state changes on the rising edge.
REQ-003 RSTB  input  1  reset, asynchronous and active-low.
REQ-004 IN_VALID  input  1  IN_DATA carries a valid state.
REQ-005 IN_READY  output  1  block can accept a state.
REQ-006 IN_DATA  input  128  AES state; [127:120] = byte 0 (row 0, col 0); column c = [127-32c -: 32].
REQ-007 OUT_VALID  output  1  OUT_DATA holds a completed result.
REQ-008 OUT_READY  input  1  consumer accepts OUT_DATA.
REQ-009 OUT_DATA  output  128  InvMixColumns(IN_DATA), same byte order as IN_DATA.

Function
REQ-010 The block SHALL compute AES InvMixColumns, the inverse of the MixColumns encoder step, on each column.
REQ-011 Per column (a0..a3), the block SHALL compute b_r = 0e*a_r ^ 0b*a_(r+1) ^ 0d*a_(r+2) ^ 09*a_(r+3), with indices mod 4.
REQ-012 All multiplication SHALL be in GF(2^8) with reduction polynomial 0x11B.
REQ-013 The multiply SHALL be built from xtime chains; no lookup tables.
REQ-014 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-015 IDLE: IN_READY = 1 and OUT_VALID = 0.
REQ-016 An accept SHALL occur on the edge where IN_VALID = 1 and IN_READY = 1; at that edge the block latches IN_DATA, clears the column counter and goes to BUSY.
REQ-017 BUSY: IN_READY = 0 and OUT_VALID = 0.
REQ-018 In BUSY, each edge SHALL transform COLS_PER_CYC columns, lowest column index first, and write them in place.
REQ-019 BUSY SHALL last exactly 4/COLS_PER_CYC cycles, then go to DONE.
REQ-020 With COLS_PER_CYC = 1, OUT_VALID SHALL rise 4 edges after the accept edge; with COLS_PER_CYC = 4, 1 edge after.
REQ-021 The column counter SHALL be 2 bits wide, advance by COLS_PER_CYC and wrap to 0 on leaving BUSY.
REQ-022 DONE: OUT_VALID = 1, IN_READY = 0, and OUT_DATA held stable until the handshake completes.
REQ-023 The block SHALL leave DONE for IDLE on the edge where OUT_READY = 1.
REQ-024 OUT_READY SHALL be ignored in IDLE and BUSY.
REQ-025 IN_VALID SHALL be ignored whenever IN_READY = 0; IN_DATA changes during BUSY or DONE SHALL NOT affect the result.
REQ-026 After the output handshake, IN_READY SHALL be 1 one cycle later; throughput is one state per 4/COLS_PER_CYC + 2 cycles.
REQ-027 IN_READY and OUT_VALID SHALL be decoded from registered state only, with no combinational path from IN_VALID or OUT_READY.

Reset
REQ-028 RSTB = 0 SHALL immediately force IDLE, IN_READY = 1, OUT_VALID = 0, OUT_DATA = 0 and counter = 0, independent of CLK.
REQ-029 A reset asserted in BUSY or DONE SHALL discard the in-flight state.
REQ-030 No output pulse SHALL occur after RSTB deasserts; the first accept is possible on the first edge with RSTB = 1.

Verification
REQ-031 Single column: column 0 = 8e4da1bc, other columns 0, COLS_PER_CYC = 1 -> OUT_VALID after 4 edges; OUT_DATA[127:96] = db135345, all other bits 0.
REQ-032 Full state {9fdc589d, d5d5d7d6, 01010101, c6c6c6c6} -> {f20a225c, d4d4d4d5, 01010101, c6c6c6c6}.
REQ-033 Same state as REQ-032 with COLS_PER_CYC = 4 -> identical OUT_DATA; OUT_VALID rises 1 edge after the accept.
REQ-034 Backpressure: hold OUT_READY = 0 for 10 cycles and toggle IN_VALID/IN_DATA meanwhile -> OUT_DATA stable, IN_READY = 0; IDLE on the first edge with OUT_READY = 1.
REQ-035 Reset mid-BUSY: pulse RSTB low at cycle 2 of BUSY -> outputs take reset values asynchronously and no OUT_VALID follows.
REQ-036 Round trip: 1000 random states through a reference MixColumns model and then this block -> output equals the original state; back-to-back accepts spaced exactly 6 cycles apart with COLS_PER_CYC = 1.
